// File: rtl/pdm_audio_fifo.sv
// PDM microphone front end: divided PDM clock, per-channel integrate-and-dump
// decimation, sample FIFO drained over a 4-register bus, level interrupt.
module pdm_audio_fifo #(
    parameter int CHANNELS     = 2,
    parameter int CLK_DIV      = 4,
    parameter int DECIM        = 64,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int IRQ_LEVEL    = 8
) (
    input  logic        i_busclk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wrdata,
    input  logic [3:0]  i_wrstrobe,
    output logic [31:0] o_rddata,
    output logic        o_irq,
    input  logic        pin_pdm_data,
    output logic        pin_pdm_clk
);
    localparam int HALF = CLK_DIV / 2;
    localparam int HW   = $clog2(HALF);
    localparam int BW   = $clog2(DECIM);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int SW   = SAMPLE_WIDTH;

    logic          run, irqEn, ovf, pdmClk, irqR, pend0, pend1;
    logic [1:0]    syncR;
    logic [HW-1:0] halfCnt;
    logic [BW-1:0] bitCnt;
    logic [SW-2:0] acc0, acc1, lat0, lat1, sel;
    logic [SW:0]   mem [FIFO_DEPTH];
    logic [LW-1:0] wrPtr, rdPtr, level;
    logic [SW-1:0] pushVal, headSample;
    logic [15:0]   headExt;
    logic [1:0]    regSel;
    logic          halfMax, riseEv, fallEv, pdmBit, frameEnd;
    logic          rdAcc, ctrlWr, flush, ovfClr, empty, full, pop, push, doPush, dropped;
    logic          unusedBits;

    assign regSel   = i_addr[3:2];
    assign halfMax  = halfCnt == HW'(HALF - 1);
    assign riseEv   = run && halfMax && !pdmClk;
    assign fallEv   = run && halfMax && pdmClk;
    assign pdmBit   = syncR[1];
    assign frameEnd = fallEv && (bitCnt == BW'(DECIM - 1));

    assign rdAcc  = i_en && (i_wrstrobe == 4'b0);
    assign ctrlWr = i_en && i_wrstrobe[0] && (regSel == 2'd0);
    assign flush  = ctrlWr && i_wrdata[2];
    assign ovfClr = i_en && i_wrstrobe[2] && (regSel == 2'd1) && i_wrdata[16];

    assign level   = wrPtr - rdPtr;
    assign empty   = level == '0;
    assign full    = level == LW'(FIFO_DEPTH);
    assign pop     = rdAcc && (regSel == 2'd2) && !empty;
    assign push    = pend0 || pend1;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign doPush  = push && !flush && (!full || pop);
    assign dropped = push && !flush && full && !pop;

    assign sel     = pend0 ? lat0 : lat1;
    assign pushVal = {sel, 1'b0} - SW'(DECIM);

    assign headSample = mem[rdPtr[AW-1:0]][SW-1:0];
    assign headExt    = 16'($signed(headSample));
    assign unusedBits = ^{i_addr[1:0], i_wrdata[31:17], i_wrdata[15:3]};

    always_comb begin
        o_rddata = '0;
        case (regSel)
            2'd0: o_rddata = {30'b0, irqEn, run};
            2'd1: o_rddata = {14'b0, run, ovf, 16'(level)};
            2'd2: if (!empty) o_rddata = {1'b1, 6'b0, mem[rdPtr[AW-1:0]][SW], 8'b0, headExt};
            default: o_rddata = {4'b0, 4'(CHANNELS), 8'(CLK_DIV), 16'(DECIM)};
        endcase
    end

    always_ff @(posedge i_busclk) begin
        if (i_reset) begin
            run <= 1'b0; irqEn <= 1'b0; ovf <= 1'b0; pdmClk <= 1'b0; irqR <= 1'b0;
            pend0 <= 1'b0; pend1 <= 1'b0; syncR <= '0; halfCnt <= '0; bitCnt <= '0;
            acc0 <= '0; acc1 <= '0; lat0 <= '0; lat1 <= '0; wrPtr <= '0; rdPtr <= '0;
        end else begin
            syncR <= {syncR[0], pin_pdm_data};
            if (ctrlWr) begin
                run   <= i_wrdata[0];
                irqEn <= i_wrdata[1];
            end
            // Stopping discards the partial frame; the next run restarts at bit 0.
            if (!run) begin
                halfCnt <= '0; pdmClk <= 1'b0; bitCnt <= '0; acc0 <= '0; acc1 <= '0;
            end else begin
                halfCnt <= halfMax ? '0 : halfCnt + HW'(1);
                if (halfMax) pdmClk <= !pdmClk;
                if (riseEv) acc0 <= acc0 + (SW-1)'(pdmBit);
                if (fallEv) begin
                    bitCnt <= frameEnd ? '0 : bitCnt + BW'(1);
                    if (frameEnd) begin
                        lat0 <= acc0;
                        lat1 <= (CHANNELS == 2) ? acc1 + (SW-1)'(pdmBit) : '0;
                        acc0 <= '0;
                        acc1 <= '0;
                    end else if (CHANNELS == 2) begin
                        acc1 <= acc1 + (SW-1)'(pdmBit);
                    end
                end
            end
            pend0 <= frameEnd;
            pend1 <= pend0 && (CHANNELS == 2);
            if (flush) begin
                wrPtr <= '0; rdPtr <= '0; ovf <= 1'b0;
            end else begin
                if (doPush) wrPtr <= wrPtr + LW'(1);
                if (pop)    rdPtr <= rdPtr + LW'(1);
                if (dropped)     ovf <= 1'b1;
                else if (ovfClr) ovf <= 1'b0;
            end
            irqR <= irqEn && (level >= LW'(IRQ_LEVEL));
        end
    end

    always_ff @(posedge i_busclk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= {pend1, pushVal};
    end

    assign o_irq       = irqR;
    assign pin_pdm_clk = pdmClk;
endmodule

// File: tb/tb_pdm_audio_fifo.sv
// Randomized bench for pdm_audio_fifo: a timing/arithmetic reference model feeds an
// expected-FIFO scoreboard that a bus monitor checks on every register read.
module tb_pdm_audio_fifo;
    localparam int HALF  = 2;
    localparam int DECIM = 8;
    localparam int DEPTH = 4;
    localparam int LVL   = 2;

    logic        i_busclk, i_reset, i_en, pin_pdm_data;
    logic [3:0]  i_addr, i_wrstrobe;
    logic [31:0] i_wrdata, o_rddata;
    logic        o_irq, pin_pdm_clk;

    pdm_audio_fifo #(.CHANNELS(2), .CLK_DIV(4), .DECIM(DECIM), .SAMPLE_WIDTH(16),
                     .FIFO_DEPTH(DEPTH), .IRQ_LEVEL(LVL)) dut (
        .i_busclk(i_busclk), .i_reset(i_reset), .i_en(i_en), .i_addr(i_addr),
        .i_wrdata(i_wrdata), .i_wrstrobe(i_wrstrobe), .o_rddata(o_rddata),
        .o_irq(o_irq), .pin_pdm_data(pin_pdm_data), .pin_pdm_clk(pin_pdm_clk));

    initial begin
        i_busclk = 1'b0;
        forever #5 i_busclk = !i_busclk;
    end

    int checks = 0, passes = 0;
    int cyc = 0, pinMode = 0;
    logic pinLog [8];
    logic chkOn = 1'b0;

    // model state
    logic [31:0] expQ [$];
    logic runM = 0, irqEnM = 0, ovfM = 0, clkM = 0, irqExp = 0;
    int runStart = 0, ones0 = 0, ones1 = 0, s0 = 0, s1 = 0, pushAt0 = -1, pushAt1 = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] entry(input int ch, input int ones);
        int v;
        v = 2 * ones - DECIM;
        return {1'b1, 6'b0, ch[0], 8'b0, 16'(v)};
    endfunction

    // microphone stand-in: a new bit every bus cycle, logged by cycle number
    initial forever begin
        logic b;
        @(negedge i_busclk);
        b = (pinMode == 0) ? 1'($urandom_range(0, 1)) : (pinMode == 1);
        pin_pdm_data = b;
        pinLog[cyc % 8] = b;
    end

    // reference model, evaluated at the end of each bus cycle from bench-driven inputs
    initial forever begin
        int k, j, t;
        logic b, drop, flushW;
        @(posedge i_busclk);
        k = cyc;
        if (i_reset) begin
            runM = 0; irqEnM = 0; ovfM = 0; clkM = 0; expQ.delete();
            ones0 = 0; ones1 = 0; pushAt0 = -1; pushAt1 = -1;
        end else begin
            flushW = i_en && i_wrstrobe[0] && i_addr[3:2] == 2'd0 && i_wrdata[2];
            drop = 0;
            if (k == pushAt0) begin
                if (expQ.size() < DEPTH) expQ.push_back(entry(0, s0)); else drop = 1;
            end
            if (k == pushAt1) begin
                if (expQ.size() < DEPTH) expQ.push_back(entry(1, s1)); else drop = 1;
            end
            if (flushW) begin
                expQ.delete(); ovfM = 0;
            end else if (drop) ovfM = 1;
            else if (i_en && i_wrstrobe[2] && i_addr[3:2] == 2'd1 && i_wrdata[16]) ovfM = 0;
            if (runM) begin
                j = k - runStart;
                if (j % HALF == HALF - 1) begin
                    t = j / HALF;              // toggle index: even = rise, odd = fall
                    b = pinLog[(k - 2) % 8];
                    if (t % 2 == 0) ones0 += int'(b);
                    else begin
                        ones1 += int'(b);
                        if ((t / 2) % DECIM == DECIM - 1) begin
                            s0 = ones0; s1 = ones1; ones0 = 0; ones1 = 0;
                            pushAt0 = k + 1; pushAt1 = k + 2;
                        end
                    end
                end
                clkM = 1'(((j + 1) / HALF) % 2);
            end else begin
                ones0 = 0; ones1 = 0; clkM = 0;
            end
            if (i_en && i_wrstrobe[0] && i_addr[3:2] == 2'd0) begin
                if (!runM && i_wrdata[0]) runStart = k + 1;
                runM = i_wrdata[0]; irqEnM = i_wrdata[1];
            end
        end
        cyc = k + 1;
    end

    // monitor: pin clock and irq every cycle, scoreboard on every register read
    initial forever begin
        logic nextIrq;
        @(negedge i_busclk);
        #1;
        if (chkOn) begin
            chk("pdm_clk", {31'b0, pin_pdm_clk}, {31'b0, clkM});
            chk("irq", {31'b0, o_irq}, {31'b0, irqExp});
        end
        nextIrq = !i_reset && irqEnM && expQ.size() >= LVL;
        if (chkOn && i_en && i_wrstrobe == 4'b0) begin
            case (i_addr[3:2])
                2'd0: chk("ctrl", o_rddata, {30'b0, irqEnM, runM});
                2'd1: chk("status", o_rddata, {14'b0, runM, ovfM, 16'(expQ.size())});
                2'd2: if (expQ.size() > 0) chk("data", o_rddata, expQ.pop_front());
                      else chk("data_empty", o_rddata, 32'h0);
                default: chk("config", o_rddata, {4'd0, 4'd2, 8'd4, 16'd8});
            endcase
        end
        irqExp = nextIrq;
    end

    task automatic busOp(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge i_busclk);
        i_en = 1'b1; i_addr = a; i_wrdata = d; i_wrstrobe = s;
        @(negedge i_busclk);
        i_en = 1'b0; i_wrstrobe = 4'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_busclk);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && expQ.size() > 0; i++) busOp(4'h8, 0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1'b1; i_en = 1'b0; i_addr = '0; i_wrdata = '0; i_wrstrobe = '0;
        idle(3);
        i_reset = 1'b0;
        chkOn = 1'b1;
        busOp(4'h4, 0, 4'h0);                 // reset status
        busOp(4'h0, 0, 4'h0);
        busOp(4'h8, 0, 4'h0);                 // empty read returns 0
        busOp(4'hC, 0, 4'h0);
        busOp(4'h4, 0, 4'h0);

        busOp(4'h0, 32'h3, 4'h1);             // run + irq_en
        idle(36);
        busOp(4'h4, 0, 4'h0);
        busOp(4'h8, 0, 4'h0);                 // pop: irq falls
        idle(100);                            // fill past full
        busOp(4'h4, 0, 4'h0);
        busOp(4'h4, 32'h0001_0000, 4'h4);     // clear overflow
        busOp(4'h4, 0, 4'h0);
        busOp(4'h8, 0, 4'h0);                 // stored entries intact
        idle(70);
        busOp(4'h8, 0, 4'h0);
        busOp(4'h4, 0, 4'h0);
        busOp(4'h0, 32'h7, 4'h1);             // flush, keep run/irq_en
        busOp(4'h4, 0, 4'h0);

        for (int i = 0; i < 400; i++) begin   // random reads while streaming
            @(negedge i_busclk);
            i_en = ($urandom_range(0, 5) == 0);
            i_addr = ($urandom_range(0, 3) == 0) ? 4'h4 : 4'h8;
            i_wrstrobe = 4'b0;
        end
        @(negedge i_busclk);
        i_en = 1'b0;
        drain();
        busOp(4'h8, 0, 4'h0);

        idle(13);
        busOp(4'h0, 32'h0, 4'h1);             // stop mid-frame
        idle(10);
        busOp(4'h4, 0, 4'h0);
        drain();
        pinMode = 1;
        idle(3);
        busOp(4'h0, 32'h1, 4'h1);             // re-run, all ones -> +8
        idle(40);
        drain();
        pinMode = 2;                          // all zeros -> -8
        idle(70);
        drain();
        busOp(4'h8, 0, 4'h0);

        pinMode = 0;
        busOp(4'h0, 32'h3, 4'h1);
        idle(75);
        @(negedge i_busclk);
        i_reset = 1'b1;                       // reset mid-frame
        @(negedge i_busclk);
        i_reset = 1'b0;
        busOp(4'h4, 0, 4'h0);
        busOp(4'h0, 0, 4'h0);
        busOp(4'h8, 0, 4'h0);
        idle(5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
